// File: rtl/presc_controller.sv
// Programmable prescaler: square-wave enable plus period tick from a runtime divisor,
// with stop / free-run / counted-burst sequencing and boundary-aligned reconfiguration.
module presc_controller #(
  parameter int unsigned DIV_W       = 20,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEFAULT_DIV = 833334
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [DIV_W-1:0] i_cfg_div,
  input  logic [1:0]       i_cfg_mode,
  input  logic [CNT_W-1:0] i_cfg_count,
  output logic             o_presc,
  output logic             o_tick,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_BURST
  } state_e;

  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             pend_q, pend_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic [1:0]       pend_mode_q, pend_mode_d;
  logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
  logic             presc_q, presc_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic             xfer;
  logic             wrap;
  logic             apply_en;
  logic [DIV_W-1:0] app_div;
  logic [1:0]       app_mode;
  logic [CNT_W-1:0] app_cnt;

  assign xfer = i_cfg_valid && ready_q;
  assign wrap = (state_q != ST_IDLE) && (cnt_q == div_q);

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    rem_d       = rem_q;
    pend_d      = pend_q;
    pend_div_d  = pend_div_q;
    pend_mode_d = pend_mode_q;
    pend_cnt_d  = pend_cnt_q;
    done_d      = 1'b0;
    apply_en    = 1'b0;
    app_div     = i_cfg_div;
    app_mode    = i_cfg_mode;
    app_cnt     = i_cfg_count;

    if (state_q == ST_IDLE) begin
      cnt_d    = '0;
      apply_en = xfer;
    end else if (wrap) begin
      cnt_d = '0;
      // A config arriving exactly on the wrap edge is applied at once rather than
      // parked, so pending is never left set once the state drops to IDLE.
      if (pend_q) begin
        apply_en = 1'b1;
        app_div  = pend_div_q;
        app_mode = pend_mode_q;
        app_cnt  = pend_cnt_q;
        pend_d   = 1'b0;
      end else if (xfer) begin
        apply_en = 1'b1;
      end else if (state_q == ST_BURST) begin
        rem_d = rem_q - 1'b1;
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (xfer) begin
        pend_d      = 1'b1;
        pend_div_d  = i_cfg_div;
        pend_mode_d = i_cfg_mode;
        pend_cnt_d  = i_cfg_count;
      end
    end

    if (apply_en) begin
      div_d = (app_div == '0) ? DIV_W'(1) : app_div;
      case (app_mode)
        MODE_RUN: state_d = ST_RUN;
        MODE_BURST: begin
          if (app_cnt != '0) begin
            state_d = ST_BURST;
            rem_d   = app_cnt;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from next-state values so they line up with cnt_q/state_q.
  assign busy_d  = (state_d != ST_IDLE);
  assign presc_d = busy_d && (cnt_d > (div_d >> 1));
  assign tick_d  = busy_d && (cnt_d == div_d);
  assign ready_d = !pend_d;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      div_q       <= DIV_W'(DEFAULT_DIV);
      rem_q       <= '0;
      pend_q      <= 1'b0;
      pend_div_q  <= '0;
      pend_mode_q <= '0;
      pend_cnt_q  <= '0;
      presc_q     <= 1'b0;
      tick_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      rem_q       <= rem_d;
      pend_q      <= pend_d;
      pend_div_q  <= pend_div_d;
      pend_mode_q <= pend_mode_d;
      pend_cnt_q  <= pend_cnt_d;
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  assign o_presc     = presc_q;
  assign o_tick      = tick_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_cfg_ready = ready_q;

endmodule
